// File: rtl/tx_frame_ctrl.sv
// UART transmit framing stage: captures a byte plus parity bit and serialises
// start, data (LSB first), optional parity and stop bits at one bit per clock.
module tx_frame_ctrl #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LVL   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Par_bit,
  input  logic                  Par_En,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Ovr_Err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    par_r;
  logic                    par_en_r;
  logic                    accept_s;
  logic                    tx_s;
  logic                    busy_s;
  logic                    tx_r;
  logic                    busy_r;
  logic                    ovr_r;

  // State, bit counter and captured frame contents
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      data_r   <= {DATA_WIDTH{1'b0}};
      par_r    <= 1'b0;
      par_en_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        data_r   <= P_Data;
        par_r    <= Par_bit;
        par_en_r <= Par_En;
      end else begin
        data_r   <= data_r;
        par_r    <= par_r;
        par_en_r <= par_en_r;
      end
    end
  end

  // Next-state and bit-counter logic
  always_comb begin
    accept_s = Data_Valid & ((state_r == ST_IDLE) | (state_r == ST_STOP));
    state_s  = state_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      ST_START: begin
        state_s = ST_DATA;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          if (par_en_r) state_s = ST_PARITY;
          else          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_PARITY: state_s = ST_STOP;
      ST_STOP: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Line level and busy flag for the upcoming state, so both can be flopped
  // and still line up with the state they describe.
  always_comb begin
    tx_s   = IDLE_LVL;
    busy_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        tx_s   = IDLE_LVL;
        busy_s = 1'b0;
      end
      ST_START: begin
        tx_s   = ~IDLE_LVL;
        busy_s = 1'b1;
      end
      ST_DATA: begin
        tx_s   = data_r[cnt_s];
        busy_s = 1'b1;
      end
      ST_PARITY: begin
        tx_s   = par_r;
        busy_s = 1'b1;
      end
      ST_STOP: begin
        tx_s   = IDLE_LVL;
        busy_s = 1'b0;
      end
      default: begin
        tx_s   = IDLE_LVL;
        busy_s = 1'b0;
      end
    endcase
  end

  // Registered outputs; overrun flags a request seen while busy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_r   <= IDLE_LVL;
      busy_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= busy_s;
      ovr_r  <= Data_Valid & busy_r;
    end
  end

  assign TX_OUT  = tx_r;
  assign Busy    = busy_r;
  assign Ovr_Err = ovr_r;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a frame-level reference model.
module tb_tx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_Data = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       Par_bit = 1'b0;
  logic       Par_En = 1'b0;
  logic       TX_OUT;
  logic       Busy;
  logic       Ovr_Err;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame in flight as a list of line bits and a position.
  logic m_frame [11];
  int   m_len = 10;
  int   m_pos = -1;
  logic m_ovr = 1'b0;

  tx_frame_ctrl #(.DATA_WIDTH(8), .IDLE_LVL(1'b1)) dut (
    .CLK(CLK), .RST(RST), .P_Data(P_Data), .Data_Valid(Data_Valid),
    .Par_bit(Par_bit), .Par_En(Par_En), .TX_OUT(TX_OUT), .Busy(Busy),
    .Ovr_Err(Ovr_Err)
  );

  always #5 CLK = ~CLK;

  function automatic logic exp_tx();
    return (m_pos < 0) ? 1'b1 : m_frame[m_pos];
  endfunction

  function automatic logic exp_busy();
    return (m_pos >= 0) && (m_pos < m_len - 1);
  endfunction

  task automatic model_reset();
    m_pos = -1;
    m_ovr = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic cycle(input logic dv, input logic [7:0] d, input logic pb, input logic pe);
    logic busy_now;
    Data_Valid = dv; P_Data = d; Par_bit = pb; Par_En = pe;
    @(posedge CLK);
    busy_now = exp_busy();
    m_ovr = dv && busy_now;
    if (dv && !busy_now) begin
      m_frame[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_frame[1+i] = d[i];
      if (pe) begin
        m_frame[9] = pb; m_frame[10] = 1'b1; m_len = 11;
      end else begin
        m_frame[9] = 1'b1; m_len = 10;
      end
      m_pos = 0;
    end else if (m_pos >= 0) begin
      m_pos++;
      if (m_pos >= m_len) m_pos = -1;
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Ovr_Err !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", Ovr_Err); end
    RST = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL idle_tx: got %b expected %b", TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL idle_busy: got %b expected %b", Busy, exp_busy()); end
    end
  endtask

  task automatic test_parity_frame();
    logic [10:0] seq = 11'd0;
    int nbusy = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) cycle(1'b1, 8'hA5, 1'b0, 1'b1);
      else        cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL par_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL par_busy[%0d]: got %b expected %b", i, Busy, exp_busy()); end
      checks++; if (Ovr_Err !== 1'b0) begin errors++; $display("FAIL par_ovr[%0d]: got %b expected 0", i, Ovr_Err); end
      if (i < 11) seq = {seq[9:0], TX_OUT};
      if (Busy) nbusy++;
    end
    checks++; if (seq !== 11'b01010010101) begin errors++; $display("FAIL par_seq: got %b expected 01010010101", seq); end
    checks++; if (nbusy != 10) begin errors++; $display("FAIL par_busy_len: got %0d expected 10", nbusy); end
  endtask

  task automatic test_no_parity();
    logic [9:0] seq = 10'd0;
    int nbusy = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 0) cycle(1'b1, 8'h3C, 1'b1, 1'b0);
      else        cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL nop_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL nop_busy[%0d]: got %b expected %b", i, Busy, exp_busy()); end
      if (i < 10) seq = {seq[8:0], TX_OUT};
      if (Busy) nbusy++;
    end
    checks++; if (seq !== 10'b0001111001) begin errors++; $display("FAIL nop_seq: got %b expected 0001111001", seq); end
    checks++; if (nbusy != 9) begin errors++; $display("FAIL nop_busy_len: got %0d expected 9", nbusy); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq = 10'd0;
    int novr = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 10)       cycle(1'b1, 8'h01, 1'b0, 1'b0);
      else if (i == 10) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      else              cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL b2b_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, Busy, exp_busy()); end
      checks++; if (Ovr_Err !== m_ovr) begin errors++; $display("FAIL b2b_ovr[%0d]: got %b expected %b", i, Ovr_Err, m_ovr); end
      if (i >= 10 && i < 20) seq = {seq[8:0], TX_OUT};
      if (Ovr_Err) novr++;
    end
    checks++; if (seq !== 10'b0111111111) begin errors++; $display("FAIL b2b_seq: got %b expected 0111111111", seq); end
    checks++; if (novr != 9) begin errors++; $display("FAIL b2b_ovr_count: got %0d expected 9", novr); end
  endtask

  task automatic test_overrun();
    int novr = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      cycle(1'b1, 8'h55, 1'b0, 1'b1);
      else if (i == 4) cycle(1'b1, 8'h00, 1'b1, 1'b0);
      else             cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL ovr_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL ovr_busy[%0d]: got %b expected %b", i, Busy, exp_busy()); end
      checks++; if (Ovr_Err !== m_ovr) begin errors++; $display("FAIL ovr_pulse[%0d]: got %b expected %b", i, Ovr_Err, m_ovr); end
      if (Ovr_Err) novr++;
    end
    checks++; if (novr != 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", novr); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) cycle(1'b1, 8'hA5, 1'b0, 1'b1);
      else        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++; if (TX_OUT !== 1'b0) begin errors++; $display("FAIL mrst_bit3: got %b expected 0", TX_OUT); end
    #1 RST = 1'b0;
    #1;
    model_reset();
    checks++; if (TX_OUT !== 1'b1) begin errors++; $display("FAIL mrst_tx_async: got %b expected 1", TX_OUT); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mrst_busy_async: got %b expected 0", Busy); end
    @(posedge CLK);
    #1 RST = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 4) cycle(1'b1, 8'h81, 1'b0, 1'b1);
      else        cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL mrst_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL mrst_busy[%0d]: got %b expected %b", i, Busy, exp_busy()); end
    end
  endtask

  task automatic test_odd_parity();
    for (int k = 0; k < 2; k++) begin
      logic pbv = 1'(k);
      for (int i = 0; i < 12; i++) begin
        if (i == 0) cycle(1'b1, 8'h07, pbv, 1'b1);
        else        cycle(1'b0, 8'h00, ~pbv, 1'b0);
        checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL odd_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
        if (i == 9) begin
          checks++; if (TX_OUT !== pbv) begin errors++; $display("FAIL odd_slot: got %b expected %b", TX_OUT, pbv); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 4), 8'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (TX_OUT !== exp_tx()) begin errors++; $display("FAIL rnd_tx[%0d]: got %b expected %b", i, TX_OUT, exp_tx()); end
      checks++; if (Busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, Busy, exp_busy()); end
      checks++; if (Ovr_Err !== m_ovr) begin errors++; $display("FAIL rnd_ovr[%0d]: got %b expected %b", i, Ovr_Err, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    test_odd_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
